adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter BITS, default 32, operand and result width in bits.
REQ-002 Parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-003 Derived localparam IDW = $clog2(NUM_REQ), requester-index width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester operation valid.
REQ-007 req_a  input  NUM_REQ*BITS  packed operand A; requester i at bits [i*BITS +: BITS].
REQ-008 req_b  input  NUM_REQ*BITS  packed operand B, same packing as req_a.
REQ-009 req_ready  output  NUM_REQ  one-hot grant; operation i accepted when req_valid[i] && req_ready[i].
REQ-010 res_valid  output  1  result register holds a valid sum.
REQ-011 res_data  output  BITS  sum of the accepted operands.
REQ-012 res_id  output  IDW  index of the requester that owns res_data.
REQ-013 res_ready  input  1  consumer accepts the result when res_valid && res_ready.

Function
REQ-014 The block SHALL contain exactly one BITS-wide two's-complement adder shared by all requesters.
REQ-015 Output register states: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-016 can_issue = !res_valid || res_ready; issue occurs only when can_issue and at least one req_valid bit is set.
REQ-017 Arbitration: round-robin starting at index ptr+1 mod NUM_REQ, searching upward with wrap-around; the first index with req_valid set wins.
REQ-018 req_ready SHALL be one-hot on the winner when an issue occurs, and all-zero otherwise; it depends combinationally on req_valid, ptr and can_issue only.
REQ-019 On issue: res_data <= A_win + B_win, res_id <= winner, res_valid <= 1, ptr <= winner; latency is exactly 1 cycle from acceptance to res_valid.
REQ-020 On result handshake with no issue in the same cycle: res_valid <= 0; res_data and res_id hold their values.
REQ-021 Simultaneous result handshake and issue: the new result replaces the old one with no bubble, sustaining one operation per cycle.
REQ-022 FULL with res_ready=0: res_valid, res_data and res_id SHALL stay stable, all req_ready bits are 0, and ptr does not advance.
REQ-023 A requester deasserting req_valid while not granted causes no state change; only one requester is accepted per cycle.
REQ-024 Without saturation, the sum SHALL be the low BITS bits of A+B (wrap-around).

Reset
REQ-025 When rst_n=0 at a clock edge: res_valid <= 0, res_data <= 0, res_id <= 0, ptr <= NUM_REQ-1, so requester 0 has first priority.
REQ-026 req_ready SHALL be all-zero in any cycle in which rst_n=0.
REQ-027 Reset mid-operation discards any pending result and performs no acceptance in that cycle.

Configuration
REQ-028 Macro ADDER_ARBITER_SAT_EN, when defined, SHALL compile in saturating addition.
REQ-029 With the macro defined: if the operand MSBs are equal and the sum MSB differs from them, the result clamps to 0x7FFF_FFFF when A is non-negative and to 0x8000_0000 when A is negative, scaled to BITS.
REQ-030 With the macro undefined: wrap-around addition per REQ-024; there is no other functional difference.

Verification
REQ-031 Reset then requester 2 alone with a=5, b=7, res_ready=1: req_ready=4'b0100 in that cycle; next cycle res_valid=1, res_data=12, res_id=2.
REQ-032 All four requesters valid continuously with res_ready=1: grants go 0,1,2,3,0,... with one result every cycle and res_id following the same sequence.
REQ-033 res_valid=1 with res_ready held 0 for 3 cycles while requests are pending: req_ready=0, and res_data and res_id are unchanged; on release, the next grant is the round-robin successor.
REQ-034 a=0x7FFF_FFFF, b=1: result 0x8000_0000 without the macro and 0x7FFF_FFFF with it; a=0x8000_0000, b=0xFFFF_FFFF: result 0x7FFF_FFFF without the macro and 0x8000_0000 with it.
REQ-035 rst_n=0 asserted while res_valid=1 and requests are pending: the next cycle has res_valid=0 and ptr reset, and the first post-reset grant goes to the lowest valid index.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter feeding one shared adder into a single-entry result register.
// Define ADDER_ARBITER_SAT_EN to build the adder as a saturating two's-complement adder.
module adder_arbiter #(
  parameter int BITS    = 32,
  parameter int NUM_REQ = 4,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*BITS-1:0] req_a,
  input  logic [NUM_REQ*BITS-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    res_valid,
  output logic [BITS-1:0]         res_data,
  output logic [IDW-1:0]          res_id,
  input  logic                    res_ready
);

  // Handshake rule for both sides: a transfer happens in exactly the cycle
  // where valid and ready are both high at the rising clock edge; nothing
  // else moves data, and the producer must hold its payload while waiting.

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  winner;
  logic            found;
  logic            can_issue;
  logic            issue;
  logic [BITS-1:0] a_win;
  logic [BITS-1:0] b_win;
  logic [BITS-1:0] sum_raw;
  logic [BITS-1:0] sum;

  // Index k positions above p, wrapped into 0..NUM_REQ-1 without a modulo.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // Search starts one past the last winner so the last winner has lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[wrap_idx(ptr, k)]) begin
        found  = 1'b1;
        winner = wrap_idx(ptr, k);
      end
    end
  end

  assign can_issue = (state == EMPTY) || res_ready;
  assign issue     = rst_n && can_issue && found;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[winner] = 1'b1;
  end

  assign a_win   = req_a[winner*BITS +: BITS];
  assign b_win   = req_b[winner*BITS +: BITS];
  assign sum_raw = a_win + b_win;

`ifdef ADDER_ARBITER_SAT_EN
  logic overflow;
  // Overflow only when both operands share a sign and the sum flips it.
  assign overflow = (a_win[BITS-1] == b_win[BITS-1]) && (sum_raw[BITS-1] != a_win[BITS-1]);
  assign sum = !overflow     ? sum_raw :
               a_win[BITS-1] ? {1'b1, {(BITS-1){1'b0}}} :
                               {1'b0, {(BITS-1){1'b1}}};
`else
  assign sum = sum_raw;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (issue) state_next = FULL;
      FULL:    if (!issue && res_ready) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    res_valid = (state == FULL);
  end

  // Payload registers hold across a drain so res_data/res_id stay at their last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_data <= '0;
      res_id   <= '0;
      ptr      <= IDW'(NUM_REQ - 1);
    end else if (issue) begin
      res_data <= sum;
      res_id   <= winner;
      ptr      <= winner;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: driver predicts grants and sums, monitor checks results.
module tb_adder_arbiter;
  localparam int BITS    = 32;
  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;
  localparam int W       = NUM_REQ * BITS;

  logic               clk;
  logic               rst_n;
  logic [NUM_REQ-1:0] req_valid;
  logic [W-1:0]       req_a;
  logic [W-1:0]       req_b;
  logic [NUM_REQ-1:0] req_ready;
  logic               res_valid;
  logic [BITS-1:0]    res_data;
  logic [IDW-1:0]     res_id;
  logic               res_ready;

  adder_arbiter #(.BITS(BITS), .NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
    .res_ready(res_ready)
  );

  // clock / reset
  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
  end
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [IDW+BITS-1:0] exp_q[$];
  int m_ptr  = NUM_REQ - 1;
  bit m_full = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference sum: exact signed sum, clamped to the representable range when saturating.
  function automatic logic [BITS-1:0] model_sum(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    logic signed [BITS:0] s;
    s = $signed({a[BITS-1], a}) + $signed({b[BITS-1], b});
`ifdef ADDER_ARBITER_SAT_EN
    if (s > $signed({2'b00, {(BITS-1){1'b1}}})) return {1'b0, {(BITS-1){1'b1}}};
    if (s < $signed({2'b11, {(BITS-1){1'b0}}})) return {1'b1, {(BITS-1){1'b0}}};
`endif
    return s[BITS-1:0];
  endfunction

  // driver: applies one cycle of stimulus and predicts the grant
  task automatic cycle(input logic rst, input logic [NUM_REQ-1:0] v,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic rr);
    int win;
    int i;
    logic [NUM_REQ-1:0] exp_rdy;
    @(negedge clk);
    rst_n = rst; req_valid = v; req_a = a; req_b = b; res_ready = rr;
    #1;
    if (!rst) begin
      check("ready_in_reset", 64'(req_ready), 64'(0));
      m_ptr  = NUM_REQ - 1;
      m_full = 1'b0;
      exp_q.delete();
      return;
    end
    check("res_valid", 64'(res_valid), 64'(m_full));
    win = -1;
    if (!m_full || rr) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        i = (m_ptr + k) % NUM_REQ;
        if (win < 0 && v[i]) win = i;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (win >= 0) begin
      exp_q.push_back({IDW'(win), model_sum(a[win*BITS +: BITS], b[win*BITS +: BITS])});
      m_ptr  = win;
      m_full = 1'b1;
    end else if (rr) begin
      m_full = 1'b0;
    end
  endtask

  // monitor: compares the presented result every cycle, pops on handshake
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && res_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {30'b0, res_id, res_data}, 64'hffff_ffff_ffff_ffff);
        end else begin
          check("result", 64'({res_id, res_data}), 64'(exp_q[0]));
          if (res_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic [BITS-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return {1'b0, {(BITS-1){1'b1}}};
      1:       return {1'b1, {(BITS-1){1'b0}}};
      2:       return '1;
      default: return BITS'($urandom);
    endcase
  endfunction

  initial begin
    logic [W-1:0] pa;
    logic [W-1:0] pb;
    logic [NUM_REQ-1:0] rv;

    // reset state
    cycle(1'b0, '0, '0, '0, 1'b0);
    cycle(1'b0, '0, '0, '0, 1'b0);
    @(posedge clk); #1;
    check("reset_valid", 64'(res_valid), 64'(0));
    check("reset_data", 64'(res_data), 64'(0));
    check("reset_id", 64'(res_id), 64'(0));

    // requester 2 alone: 5 + 7
    pa = '0; pb = '0;
    pa[2*BITS +: BITS] = 5;
    pb[2*BITS +: BITS] = 7;
    cycle(1'b1, 4'b0100, pa, pb, 1'b1);
    check("dir_grant2", 64'(req_ready), 64'(4'b0100));
    @(posedge clk); #1;
    check("dir_sum", 64'(res_data), 64'(12));
    check("dir_id", 64'(res_id), 64'(2));

    // overflow boundaries through requester 0
    pa = '0; pb = '0;
    pa[0 +: BITS] = 32'h7FFF_FFFF; pb[0 +: BITS] = 32'h1;
    cycle(1'b1, 4'b0001, pa, pb, 1'b1);
    @(posedge clk); #1;
`ifdef ADDER_ARBITER_SAT_EN
    check("ovf_pos", 64'(res_data), 64'(32'h7FFF_FFFF));
`else
    check("ovf_pos", 64'(res_data), 64'(32'h8000_0000));
`endif
    pa[0 +: BITS] = 32'h8000_0000; pb[0 +: BITS] = 32'hFFFF_FFFF;
    cycle(1'b1, 4'b0001, pa, pb, 1'b1);
    @(posedge clk); #1;
`ifdef ADDER_ARBITER_SAT_EN
    check("ovf_neg", 64'(res_data), 64'(32'h8000_0000));
`else
    check("ovf_neg", 64'(res_data), 64'(32'h7FFF_FFFF));
`endif

    // all requesters continuously valid, back-to-back results
    for (int c = 0; c < 9; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        pa[i*BITS +: BITS] = BITS'($urandom);
        pb[i*BITS +: BITS] = BITS'($urandom);
      end
      cycle(1'b1, 4'b1111, pa, pb, 1'b1);
    end

    // stall for 3 cycles with requests pending, then release
    for (int c = 0; c < 3; c++) cycle(1'b1, 4'b1111, pa, pb, 1'b0);
    cycle(1'b1, 4'b1111, pa, pb, 1'b1);

    // reset while full with requests pending, then lowest valid index wins
    cycle(1'b1, 4'b1111, pa, pb, 1'b0);
    cycle(1'b0, 4'b1111, pa, pb, 1'b0);
    cycle(1'b1, 4'b1010, pa, pb, 1'b1);
    check("post_reset_grant", 64'(req_ready), 64'(4'b0010));

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        pa[i*BITS +: BITS] = pick();
        pb[i*BITS +: BITS] = pick();
      end
      rv = NUM_REQ'($urandom);
      cycle(($urandom_range(0, 49) != 0), rv, pa, pb, ($urandom_range(0, 3) != 0));
    end

    // drain
    for (int c = 0; c < 4; c++) cycle(1'b1, '0, '0, '0, 1'b1);
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
